// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard and sequencing controller for the five-stage
//               core. Inserts load-use bubbles, flushes wrong-path
//               instructions on taken branches and jumps, and interlocks ID
//               against an in-flight multi-cycle multiply/divide unit (MDU).
//               Also keeps saturating stall and flush performance counters.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk             in  : core clock; state updates on posedge, pipeline
//                         registers downstream capture on negedge
//   reset_n         in  : asynchronous active-low reset
//   id_rs, id_rt    in  : ID-stage source register indices
//   id_rs_used      in  : ID instruction really reads rs
//   id_rt_used      in  : ID instruction really reads rt
//   id_jump         in  : ID instruction is an unconditional jump
//   id_mdu_use      in  : ID instruction is an MDU op or reads HI/LO
//   ex_load         in  : EX instruction is a load
//   ex_dest         in  : EX load destination index
//   ex_branch_taken in  : EX branch resolved taken
//   ex_mdu_start    in  : EX instruction launches the MDU
//   pc_hold         out : PC keeps its value
//   ifid_hold       out : IF/ID keeps its value
//   ifid_wipe       out : IF/ID loads a bubble
//   idex_wipe       out : ID/EX loads a bubble
//   mdu_busy        out : MDU occupied
//   stall_count     out : saturating count of cycles with pc_hold high
//   flush_count     out : saturating count of taken-branch flushes
// ============================================================================
module hazard_ctrl #(
    parameter int REG_W   = 6,
    parameter int MDU_LAT = 8,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic             id_jump,
    input  logic             id_mdu_use,
    input  logic             ex_load,
    input  logic [REG_W-1:0] ex_dest,
    input  logic             ex_branch_taken,
    input  logic             ex_mdu_start,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             ifid_wipe,
    output logic             idex_wipe,
    output logic             mdu_busy,
    output logic [15:0]      stall_count,
    output logic [15:0]      flush_count
);

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MDU_WAIT = 1'b1
    } state_t;

    // The counter holds the number of busy cycles still to come after the
    // current one, so it is loaded with MDU_LAT-1 and leaves at zero.
    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(MDU_LAT - 1);
    localparam logic [15:0]      C_SAT_MAX  = 16'hFFFF;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [15:0]      r_stall_count;
    logic [15:0]      r_flush_count;

    logic w_lu;
    logic w_mh;

    // Register $0 is never written, so a load targeting it cannot create a
    // real dependency.
    assign w_lu = ex_load && (ex_dest != '0) &&
                  ((id_rs_used && (id_rs == ex_dest)) ||
                   (id_rt_used && (id_rt == ex_dest)));

    assign w_mh = (r_state == ST_MDU_WAIT) && id_mdu_use;

    // Hold/wipe controls must settle in the high phase so the negedge-clocked
    // pipeline registers see them. While reset is held the front end is
    // frozen and both pipeline registers are forced to bubbles.
    always_comb begin
        pc_hold   = 1'b0;
        ifid_hold = 1'b0;
        ifid_wipe = 1'b0;
        idex_wipe = 1'b0;
        if (!reset_n) begin
            pc_hold   = 1'b1;
            ifid_wipe = 1'b1;
            idex_wipe = 1'b1;
        end else if (ex_branch_taken) begin
            // Both younger instructions are on the wrong path.
            ifid_wipe = 1'b1;
            idex_wipe = 1'b1;
        end else if (w_lu || w_mh) begin
            // Freeze PC and IF/ID; a held jump re-presents next cycle.
            pc_hold   = 1'b1;
            ifid_hold = 1'b1;
            idex_wipe = 1'b1;
        end else if (id_jump) begin
            ifid_wipe = 1'b1;
        end
    end

    // State is cleared asynchronously, so mdu_busy drops the moment reset
    // asserts even in the middle of an MDU wait.
    assign mdu_busy    = (r_state == ST_MDU_WAIT);
    assign stall_count = r_stall_count;
    assign flush_count = r_flush_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_RUN;
            r_cnt         <= '0;
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    // A start coinciding with a taken branch belongs to a
                    // wrong-path instruction and is dropped.
                    if (ex_mdu_start && !ex_branch_taken) begin
                        r_state <= ST_MDU_WAIT;
                        r_cnt   <= C_CNT_LOAD;
                    end
                end
                ST_MDU_WAIT: begin
                    // The running MDU op is older than any branch in EX, so
                    // a flush never cancels it; new starts are ignored here.
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                    r_cnt   <= '0;
                end
            endcase

            if (pc_hold && (r_stall_count != C_SAT_MAX)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
            if (ex_branch_taken && (r_flush_count != C_SAT_MAX)) begin
                r_flush_count <= r_flush_count + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl. Directed scenarios plus
//               randomized traffic compared against a cycle-level reference
//               model built from the priority rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int REG_W   = 6;
    localparam int MDU_LAT = 8;
    localparam int CNT_W   = 4;

    // Control vector order: {pc_hold, ifid_hold, ifid_wipe, idex_wipe}
    localparam logic [3:0] C_NONE   = 4'b0000;
    localparam logic [3:0] C_STALL  = 4'b1101;
    localparam logic [3:0] C_FLUSH  = 4'b0011;
    localparam logic [3:0] C_JUMP   = 4'b0010;
    localparam logic [3:0] C_INRST  = 4'b1011;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [REG_W-1:0] id_rs, id_rt, ex_dest;
    logic             id_rs_used, id_rt_used, id_jump, id_mdu_use;
    logic             ex_load, ex_branch_taken, ex_mdu_start;
    logic             pc_hold, ifid_hold, ifid_wipe, idex_wipe, mdu_busy;
    logic [15:0]      stall_count, flush_count;

    int errors = 0;
    int checks = 0;

    // Reference model state: remaining busy cycles and counter values.
    int m_busy_left;
    int m_stall;
    int m_flush;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .REG_W  (REG_W),
        .MDU_LAT(MDU_LAT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_rs_used     (id_rs_used),
        .id_rt_used     (id_rt_used),
        .id_jump        (id_jump),
        .id_mdu_use     (id_mdu_use),
        .ex_load        (ex_load),
        .ex_dest        (ex_dest),
        .ex_branch_taken(ex_branch_taken),
        .ex_mdu_start   (ex_mdu_start),
        .pc_hold        (pc_hold),
        .ifid_hold      (ifid_hold),
        .ifid_wipe      (ifid_wipe),
        .idex_wipe      (idex_wipe),
        .mdu_busy       (mdu_busy),
        .stall_count    (stall_count),
        .flush_count    (flush_count)
    );

    function automatic logic [3:0] ctrl_now();
        return {pc_hold, ifid_hold, ifid_wipe, idex_wipe};
    endfunction

    // Expected controls from the priority rules and the current inputs.
    function automatic logic [3:0] exp_ctrl();
        bit lu, mh;
        lu = ex_load && (ex_dest != 0) &&
             ((id_rs_used && id_rs == ex_dest) || (id_rt_used && id_rt == ex_dest));
        mh = (m_busy_left > 0) && id_mdu_use;
        if (ex_branch_taken) return C_FLUSH;
        if (lu || mh)        return C_STALL;
        if (id_jump)         return C_JUMP;
        return C_NONE;
    endfunction

    task automatic set_idle();
        id_rs = '0; id_rt = '0; ex_dest = '0;
        id_rs_used = 0; id_rt_used = 0; id_jump = 0; id_mdu_use = 0;
        ex_load = 0; ex_branch_taken = 0; ex_mdu_start = 0;
    endtask

    // Advance one posedge, updating the model from the inputs seen there.
    task automatic clk_edge();
        logic [3:0] c;
        @(posedge clk);
        c = exp_ctrl();
        if (c[3] && m_stall < 65535) m_stall++;
        if (ex_branch_taken && m_flush < 65535) m_flush++;
        if (m_busy_left > 0) m_busy_left--;
        else if (ex_mdu_start && !ex_branch_taken) m_busy_left = MDU_LAT;
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        reset_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1;
        m_busy_left = 0; m_stall = 0; m_flush = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        ex_mdu_start = 1;
        clk_edge();
        set_idle();
        repeat (2) clk_edge();
        @(negedge clk);
        checks++;
        if (mdu_busy !== 1'b1) begin
            errors++; $display("FAIL reset_pre_busy: got %b expected 1", mdu_busy);
        end
        #2 reset_n = 0;
        #1;
        checks++;
        if (mdu_busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b expected 0", mdu_busy);
        end
        checks++;
        if (ctrl_now() !== C_INRST) begin
            errors++; $display("FAIL reset_ctrl: got %b expected %b", ctrl_now(), C_INRST);
        end
        @(posedge clk);
        @(negedge clk);
        reset_n = 1;
        m_busy_left = 0; m_stall = 0; m_flush = 0;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if ({ctrl_now(), mdu_busy, stall_count, flush_count} !== {C_NONE, 1'b0, 32'd0}) begin
            errors++;
            $display("FAIL reset_after: got ctrl=%b busy=%b stall=%0d flush=%0d expected all zero",
                     ctrl_now(), mdu_busy, stall_count, flush_count);
        end
        clk_edge();
    endtask

    task automatic test_load_use();
        do_reset();
        ex_load = 1; ex_dest = 6'd5; id_rs = 6'd5; id_rs_used = 1;
        @(negedge clk);
        checks++;
        if (ctrl_now() !== C_STALL) begin
            errors++; $display("FAIL lu_stall: got %b expected %b", ctrl_now(), C_STALL);
        end
        clk_edge();
        ex_load = 0;  // bubble now in EX
        @(negedge clk);
        checks++;
        if (ctrl_now() !== C_NONE || stall_count !== 16'd1) begin
            errors++; $display("FAIL lu_release: got ctrl=%b stall=%0d expected ctrl=0000 stall=1",
                               ctrl_now(), stall_count);
        end
        clk_edge();
        ex_load = 1; ex_dest = 6'd0; id_rs = 6'd0; id_rs_used = 1;
        @(negedge clk);
        checks++;
        if (ctrl_now() !== C_NONE) begin
            errors++; $display("FAIL lu_dest0: got %b expected %b", ctrl_now(), C_NONE);
        end
        clk_edge();
        ex_dest = 6'd5; id_rs = 6'd5; id_rs_used = 0;
        @(negedge clk);
        checks++;
        if (ctrl_now() !== C_NONE) begin
            errors++; $display("FAIL lu_unused: got %b expected %b", ctrl_now(), C_NONE);
        end
        clk_edge();
        id_rt = 6'd5; id_rt_used = 1;
        @(negedge clk);
        checks++;
        if (ctrl_now() !== C_STALL) begin
            errors++; $display("FAIL lu_rt: got %b expected %b", ctrl_now(), C_STALL);
        end
        clk_edge();
        set_idle();
        @(negedge clk);
        checks++;
        if (stall_count !== 16'd2) begin
            errors++; $display("FAIL lu_count: got %0d expected 2", stall_count);
        end
        clk_edge();
    endtask

    task automatic test_branch_vs_stall();
        do_reset();
        ex_load = 1; ex_dest = 6'd7; id_rt = 6'd7; id_rt_used = 1;
        ex_branch_taken = 1; id_jump = 1;
        @(negedge clk);
        checks++;
        if (ctrl_now() !== C_FLUSH) begin
            errors++; $display("FAIL br_prio: got %b expected %b", ctrl_now(), C_FLUSH);
        end
        clk_edge();
        set_idle();
        @(negedge clk);
        checks++;
        if (flush_count !== 16'd1 || stall_count !== 16'd0) begin
            errors++; $display("FAIL br_counts: got flush=%0d stall=%0d expected flush=1 stall=0",
                               flush_count, stall_count);
        end
        clk_edge();
    endtask

    task automatic test_mdu_interlock();
        do_reset();
        ex_mdu_start = 1;
        @(negedge clk);
        checks++;
        if (mdu_busy !== 1'b0) begin
            errors++; $display("FAIL mdu_c0: got %b expected 0", mdu_busy);
        end
        clk_edge();
        ex_mdu_start = 0; id_mdu_use = 1;
        for (int k = 1; k <= MDU_LAT; k++) begin
            @(negedge clk);
            checks++;
            if (mdu_busy !== 1'b1 || ctrl_now() !== C_STALL) begin
                errors++; $display("FAIL mdu_c%0d: got busy=%b ctrl=%b expected busy=1 ctrl=%b",
                                   k, mdu_busy, ctrl_now(), C_STALL);
            end
            clk_edge();
        end
        @(negedge clk);
        checks++;
        if (mdu_busy !== 1'b0 || ctrl_now() !== C_NONE || stall_count !== 16'd8) begin
            errors++; $display("FAIL mdu_end: got busy=%b ctrl=%b stall=%0d expected 0 0000 8",
                               mdu_busy, ctrl_now(), stall_count);
        end
        clk_edge();
        set_idle();
    endtask

    task automatic test_mdu_branch();
        do_reset();
        ex_mdu_start = 1;
        clk_edge();
        ex_mdu_start = 0;
        for (int k = 1; k <= MDU_LAT; k++) begin
            ex_branch_taken = (k == 3);
            ex_mdu_start = (k == 5);  // ignored while waiting
            @(negedge clk);
            checks++;
            if (mdu_busy !== 1'b1 || ctrl_now() !== ((k == 3) ? C_FLUSH : C_NONE)) begin
                errors++; $display("FAIL mdubr_c%0d: got busy=%b ctrl=%b", k, mdu_busy, ctrl_now());
            end
            clk_edge();
        end
        set_idle();
        @(negedge clk);
        checks++;
        if (mdu_busy !== 1'b0 || flush_count !== 16'd1) begin
            errors++; $display("FAIL mdubr_end: got busy=%b flush=%0d expected 0 1",
                               mdu_busy, flush_count);
        end
        clk_edge();
    endtask

    task automatic test_jump_stall();
        do_reset();
        ex_load = 1; ex_dest = 6'd9; id_rs = 6'd9; id_rs_used = 1; id_jump = 1;
        @(negedge clk);
        checks++;
        if (ctrl_now() !== C_STALL) begin
            errors++; $display("FAIL jmp_held: got %b expected %b", ctrl_now(), C_STALL);
        end
        clk_edge();
        ex_load = 0;
        @(negedge clk);
        checks++;
        if (ctrl_now() !== C_JUMP) begin
            errors++; $display("FAIL jmp_next: got %b expected %b", ctrl_now(), C_JUMP);
        end
        clk_edge();
        set_idle();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            id_rs           = REG_W'($urandom_range(0, 3));
            id_rt           = REG_W'($urandom_range(0, 3));
            ex_dest         = REG_W'($urandom_range(0, 3));
            id_rs_used      = 1'($urandom_range(0, 1));
            id_rt_used      = 1'($urandom_range(0, 1));
            id_jump         = ($urandom_range(0, 4) == 0);
            id_mdu_use      = ($urandom_range(0, 2) == 0);
            ex_load         = ($urandom_range(0, 2) == 0);
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            ex_mdu_start    = ($urandom_range(0, 9) == 0);
            @(negedge clk);
            checks++;
            if (ctrl_now() !== exp_ctrl() || mdu_busy !== (m_busy_left > 0) ||
                stall_count !== 16'(m_stall) || flush_count !== 16'(m_flush)) begin
                errors++;
                $display("FAIL rand_%0d: got ctrl=%b busy=%b stall=%0d flush=%0d expected ctrl=%b busy=%b stall=%0d flush=%0d",
                         n, ctrl_now(), mdu_busy, stall_count, flush_count,
                         exp_ctrl(), (m_busy_left > 0), m_stall, m_flush);
            end
            clk_edge();
        end
        set_idle();
    endtask

    task automatic test_saturation();
        do_reset();
        ex_load = 1; ex_dest = 6'd3; id_rs = 6'd3; id_rs_used = 1;
        repeat (65534) clk_edge();
        @(negedge clk);
        checks++;
        if (stall_count !== 16'hFFFE) begin
            errors++; $display("FAIL sat_pre: got %h expected fffe", stall_count);
        end
        repeat (6) clk_edge();
        @(negedge clk);
        checks++;
        if (stall_count !== 16'hFFFF || stall_count !== 16'(m_stall)) begin
            errors++; $display("FAIL sat_hold: got %h expected ffff", stall_count);
        end
        clk_edge();
        set_idle();
    endtask

    initial begin
        set_idle();
        test_reset();
        test_load_use();
        test_branch_vs_stall();
        test_mdu_interlock();
        test_mdu_branch();
        test_jump_stall();
        test_random();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage core. Watches the ID-stage register indices, the EX-stage load/branch/multi-cycle status, and drives the hold and wipe controls of the PC, the IF/ID register and the ID/EX register (the extended D register's `wipe` input). It inserts load-use bubbles, flushes wrong-path instructions on taken branches and jumps, and interlocks ID against an in-flight multi-cycle multiply/divide unit (MDU). It also keeps saturating performance counters.

## Interface
- `REG_W`, 6: register index width (matches rt/rd fields).
- `MDU_LAT`, 8: cycles the MDU stays busy after a start; legal range is 1..2^CNT_W.
- `CNT_W`, 4: MDU down-counter width.
- `clk` in 1: core clock. Controller state updates on posedge; pipeline registers capture on negedge.
- `reset_n` in 1: asynchronous, active-low reset.
- `id_rs`, `id_rt` in REG_W: source indices of the ID instruction.
- `id_rs_used`, `id_rt_used` in 1: the corresponding source is actually read.
- `id_jump` in 1: ID instruction is an unconditional jump.
- `id_mdu_use` in 1: ID instruction is an MDU op or reads HI/LO.
- `ex_load` in 1: EX instruction is a load.
- `ex_dest` in REG_W: EX load destination index.
- `ex_branch_taken` in 1: EX branch resolved taken.
- `ex_mdu_start` in 1: EX instruction launches the MDU.
- `pc_hold` out 1: PC keeps its value.
- `ifid_hold` out 1: IF/ID keeps its value.
- `ifid_wipe` out 1: IF/ID loads a bubble.
- `idex_wipe` out 1: ID/EX loads a bubble (add $0,$0,$0).
- `mdu_busy` out 1: MDU occupied.
- `stall_count` out 16: saturating count of cycles with `pc_hold`=1.
- `flush_count` out 16: saturating count of taken-branch flushes.

## Operation
- FSM states: RUN and MDU_WAIT. A CNT_W-bit down-counter `cnt` runs alongside.
- All hold and wipe outputs are combinational from the state and the inputs. They settle in the high phase, before the negedge capture.
- Load-use hazard `lu`: `ex_load` && `ex_dest`≠0 && ((`id_rs_used` && `id_rs`==`ex_dest`) || (`id_rt_used` && `id_rt`==`ex_dest`)).
- MDU hazard `mh`: state==MDU_WAIT && `id_mdu_use`.
- Output priority, highest first:
  1. `ex_branch_taken`: `ifid_wipe`=1, `idex_wipe`=1, `pc_hold`=0, `ifid_hold`=0. This overrides `lu`, `mh` and `id_jump`.
  2. `lu` or `mh`: `pc_hold`=1, `ifid_hold`=1, `idex_wipe`=1, `ifid_wipe`=0. `id_jump` is ignored this cycle; the jump re-presents next cycle.
  3. `id_jump`: `ifid_wipe`=1 only.
  4. Otherwise all four controls are 0.
- RUN:
  - `ex_mdu_start` && !`ex_branch_taken` → next state MDU_WAIT, `cnt`←MDU_LAT−1.
  - If both are asserted (illegal), the branch wins and the start is ignored.
- MDU_WAIT:
  - `mdu_busy`=1.
  - `cnt`≠0 → `cnt` decrements.
  - `cnt`==0 → next state RUN.
  - A taken branch does not cancel the MDU, because the MDU op is older.
  - `ex_mdu_start` is ignored in this state.
- Counters:
  - `stall_count` increments each posedge where `pc_hold`=1.
  - `flush_count` increments each posedge where `ex_branch_taken`=1.
  - Both saturate at 16'hFFFF.

## Timing
- Reset (`reset_n`=0, asynchronous):
  - Registers: state=RUN, `cnt`=0, both counters=0.
  - Outputs while reset is held: `pc_hold`=1, `ifid_wipe`=1, `idex_wipe`=1, `ifid_hold`=0, `mdu_busy`=0.
  - Reset mid-MDU aborts the wait immediately.
- Load-use penalty is exactly 1 cycle. The next cycle `ex_load` reflects the bubble, so `lu` drops without any extra state.
- MDU timing: `ex_mdu_start` sampled in cycle n gives `mdu_busy`=1 in cycles n+1 through n+MDU_LAT, then 0 in cycle n+MDU_LAT+1.
  - A dependent ID instruction stalls in every busy cycle and proceeds in the first RUN cycle.
  - MDU_LAT=1 gives exactly one busy cycle.
- Branch flush has zero latency: the flush occurs in the same cycle `ex_branch_taken` is seen.

## Test plan
- Reset: hold `reset_n`=0 mid-MDU_WAIT → immediately `mdu_busy`=0, `pc_hold`=1, both wipes=1. After release, counters read 0 and there are no stalls.
- Load-use: `ex_load`=1, `ex_dest`=5, `id_rs`=5, `id_rs_used`=1 → one cycle of `pc_hold`=`ifid_hold`=`idex_wipe`=1, `stall_count`=1. Same case with `ex_dest`=0, or with `id_rs_used`=0 → no stall.
- Branch vs stall: load-use hazard plus `ex_branch_taken`=1 in the same cycle → `ifid_wipe`=`idex_wipe`=1, `pc_hold`=0, `flush_count`=1, `stall_count` unchanged.
- MDU interlock, MDU_LAT=8: start in cycle 0, `id_mdu_use`=1 from cycle 1 → stalls in cycles 1-8, `mdu_busy` falls at cycle 9, `stall_count`=8.
- MDU with branch: taken branch in cycle 3 of MDU_WAIT → flush occurs, and `mdu_busy` still ends after exactly MDU_LAT cycles.
- Jump under stall and saturation:
  - `id_jump`=1 during a load-use stall → no `ifid_wipe`; the next cycle gives `ifid_wipe`=1.
  - Force 65540 stall cycles → `stall_count`=16'hFFFF.
